// File: rtl/bus_pkg.sv
// Shared constants and types for the register-to-bus sink: widths, source lane indices
// and the bus controller state encoding.
package bus_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_SRC    = 24;
    localparam int unsigned SEL_WIDTH  = 5;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R1     = 1;
    localparam int unsigned SRC_R2     = 2;
    localparam int unsigned SRC_R3     = 3;
    localparam int unsigned SRC_R4     = 4;
    localparam int unsigned SRC_R5     = 5;
    localparam int unsigned SRC_R6     = 6;
    localparam int unsigned SRC_R7     = 7;
    localparam int unsigned SRC_R8     = 8;
    localparam int unsigned SRC_R9     = 9;
    localparam int unsigned SRC_R10    = 10;
    localparam int unsigned SRC_R11    = 11;
    localparam int unsigned SRC_R12    = 12;
    localparam int unsigned SRC_R13    = 13;
    localparam int unsigned SRC_R14    = 14;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_C      = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } bus_state_t;

endpackage

// File: rtl/onehot_prio_encoder.sv
// Combinational lowest-index encoder for a strobe vector; also flags whether any bit
// and whether more than one bit is set.
module onehot_prio_encoder
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = NUM_SRC,
    parameter int unsigned IDX_WIDTH = SEL_WIDTH
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any_set,
    output logic                 multi_set
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_WIDTH'(i);
            end
        end
    end

    assign any_set   = |vec;
    assign multi_set = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/bus_mux_sink.sv
// Shared-bus sink: selects the lane named by the one-hot out strobes, registers it onto the
// bus, counts single-driver transfers and latches multi-driver faults. BUS_MUX_HOLD_EN keeps
// the last bus value on idle cycles instead of forcing zero.
module bus_mux_sink #(
    parameter int unsigned NUM_SRC    = bus_pkg::NUM_SRC,
    parameter int unsigned DATA_WIDTH = bus_pkg::DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = bus_pkg::SEL_WIDTH,
    parameter int unsigned CNT_WIDTH  = bus_pkg::CNT_WIDTH
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_out,
    input  logic                          conflict_clr,
    output logic [DATA_WIDTH-1:0]         bus_data,
    output logic                          bus_valid,
    output logic [SEL_WIDTH-1:0]          bus_sel,
    output logic                          conflict,
    output logic [CNT_WIDTH-1:0]          xfer_count
);
    import bus_pkg::*;

    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] lanes;
    logic [SEL_WIDTH-1:0]               enc_idx;
    logic                               enc_any;
    logic                               enc_multi;

    bus_state_t                         state_q, state_d;
    logic [DATA_WIDTH-1:0]              bus_data_q, bus_data_d;
    logic [SEL_WIDTH-1:0]               bus_sel_q, bus_sel_d;
    logic [CNT_WIDTH-1:0]               xfer_count_q, xfer_count_d;

    assign lanes = src_data;

    onehot_prio_encoder #(
        .WIDTH     (NUM_SRC),
        .IDX_WIDTH (SEL_WIDTH)
    ) u_enc (
        .vec       (src_out),
        .idx       (enc_idx),
        .any_set   (enc_any),
        .multi_set (enc_multi)
    );

    always_comb begin
        state_d      = state_q;
        bus_data_d   = bus_data_q;
        bus_sel_d    = bus_sel_q;
        xfer_count_d = xfer_count_q;

        case (state_q)
            IDLE, DRIVE: begin
                if (enc_multi) begin
                    // Capture the lowest contender so software can see who collided.
                    state_d    = FAULT;
                    bus_data_d = lanes[enc_idx];
                    bus_sel_d  = enc_idx;
                end else if (enc_any) begin
                    state_d    = DRIVE;
                    bus_data_d = lanes[enc_idx];
                    bus_sel_d  = enc_idx;
                    if (xfer_count_q != '1) begin
                        xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
                    end
                end else begin
                    state_d = IDLE;
`ifndef BUS_MUX_HOLD_EN
                    bus_data_d = '0;
                    bus_sel_d  = '0;
`endif
                end
            end
            FAULT: begin
                // A fresh conflict in the clearing cycle keeps the fault latched.
                if (conflict_clr && !enc_multi) begin
                    state_d = IDLE;
`ifndef BUS_MUX_HOLD_EN
                    bus_data_d = '0;
                    bus_sel_d  = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            bus_data_q   <= '0;
            bus_sel_q    <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_data_q   <= bus_data_d;
            bus_sel_q    <= bus_sel_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus_data   = bus_data_q;
    assign bus_sel    = bus_sel_q;
    assign bus_valid  = (state_q == DRIVE);
    assign conflict   = (state_q == FAULT);
    assign xfer_count = xfer_count_q;

endmodule

// File: doc/bus_mux_sink.md
Name: bus_mux_sink

Overview:
- Receiving end of the register-to-bus interface. Each datapath register presents its gated output on its BusMuxIn lane; this block collects those lanes, selects one from the one-hot "out" strobes and drives the registered shared bus.
- Encodes the selected source index and counts completed transfers.
- Detects multiple-driver conflicts and holds a fault state until software or the controller clears it.
- Sits between the register bank outputs and every bus-capturing register (MAR, MDR, Y, Z, IR, R0-R15 inputs).

Parameters:
- NUM_SRC, 24, number of bus source lanes (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C).
- DATA_WIDTH, 32, bus and lane width in bits.
- SEL_WIDTH, 5, encoded source index width; must satisfy 2^SEL_WIDTH >= NUM_SRC.
- CNT_WIDTH, 16, transfer counter width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- clear  in  1  synchronous active-high reset.
- src_data  in  NUM_SRC*DATA_WIDTH  concatenated BusMuxIn lanes; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_out  in  NUM_SRC  one-hot drive strobes (R0out, R1out, ..., Cout).
- conflict_clr  in  1  pulse; leaves FAULT state.
- bus_data  out  DATA_WIDTH  registered bus value.
- bus_valid  out  1  bus_data holds a legitimately selected lane this cycle.
- bus_sel  out  SEL_WIDTH  encoded index of the lane on bus_data.
- conflict  out  1  sticky multi-driver flag; equals (state==FAULT).
- xfer_count  out  CNT_WIDTH  saturating count of single-driver transfers.

Behaviour:
- Reset: one clock, synchronous, active-high. On a clock edge with clear=1, all outputs go to 0 (bus_data, bus_valid, bus_sel, conflict, xfer_count) and state goes to IDLE. clear has priority over every other input, including mid-transfer and during FAULT.
- Latency: one cycle. src_out and src_data are sampled at edge N; the results are visible after edge N.
- States:
  - IDLE: no driver in the last sample.
  - DRIVE: exactly one driver in the last sample.
  - FAULT: a conflict was seen and has not been cleared.
- Transitions out of IDLE or DRIVE, per sampled popcount(src_out):
  - 0: go to IDLE; bus_valid<=0; bus_data<=0; bus_sel<=0.
  - 1: go to DRIVE; bus_data<=lane[k]; bus_sel<=k; bus_valid<=1; xfer_count<=xfer_count+1, saturating at all-ones (no wrap).
  - >=2: go to FAULT; bus_data<=lane[lowest set index]; bus_sel<=that index; bus_valid<=0; xfer_count unchanged.
- In FAULT:
  - bus_valid is held at 0, and bus_data and bus_sel are held at their values from the fault cycle. src_out is ignored except for conflict detection.
  - conflict_clr=1 with popcount<=1: go to IDLE. No transfer is performed that cycle; bus_data goes to 0.
  - conflict_clr=1 with popcount>=2 in the same cycle: the new conflict wins and the block stays in FAULT.
- conflict_clr outside FAULT: no effect.
- Lanes are passed through unmodified. The R0 BAout zero-masking happens upstream in the register, so lane 0 may legitimately read 0.
- Lane index is width-checked: bits of src_out at or above NUM_SRC do not exist. bus_sel is zero-extended to SEL_WIDTH.

Optional Feature:
- Macro: BUS_MUX_HOLD_EN.
- Defined: when popcount==0 outside FAULT, bus_data and bus_sel keep their previous values (bus keeper behaviour); bus_valid still goes to 0. Leaving FAULT via conflict_clr also keeps bus_data.
- Undefined: bus_data and bus_sel are forced to 0 on an idle cycle, as specified above.

Decomposition:
- Shared package bus_pkg:
  - DATA_WIDTH, NUM_SRC and SEL_WIDTH constants.
  - Source index constants: SRC_R0=0 through SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23.
  - bus_state_t enum {IDLE, DRIVE, FAULT}.
- Sub-module onehot_prio_encoder: purely combinational. Takes a NUM_SRC vector and outputs the lowest set index, any_set and multi_set. Reused by the register-select (Gra/Grb/Grc) logic.

Test Plan:
- clear=1 for 2 cycles with random src_out → all outputs 0, state IDLE; release clear and check that xfer_count starts from 0.
- src_out=1<<20 (PCout), lane 20=32'h0000_0040 → next cycle bus_data=32'h40, bus_sel=20, bus_valid=1, xfer_count=1. Then src_out=0 → bus_valid=0 and bus_data=0 (bus_data=32'h40 when BUS_MUX_HOLD_EN is defined).
- src_out=(1<<3)|(1<<21), lane3=32'hAAAA_0003 → conflict=1, bus_valid=0, bus_sel=3, bus_data=32'hAAAA0003. Conflict stays 1 for 10 cycles of valid single strobes; xfer_count unchanged.
- In FAULT: conflict_clr=1 together with src_out=(1<<0)|(1<<1) → remains FAULT. Next: conflict_clr=1 with src_out=0 → IDLE, conflict=0. Then src_out=1<<0 with lane0=0 (BAout masked) → bus_valid=1, bus_data=0.
- Preload xfer_count near all-ones (CNT_WIDTH=4): 17 consecutive single-driver cycles → xfer_count saturates at 4'hF.
- Assert clear while in DRIVE with src_out=1<<5 held → next cycle all outputs 0. On the cycle after clear deasserts, the transfer resumes with bus_sel=5 and xfer_count=1.
